// File: rtl/fpu_sched_pkg.sv
// fpu_sched_pkg: types and constants shared by the fpu and its request scheduler.
`default_nettype none

package fpu_sched_pkg;

   localparam int FLOAT_W     = 32;
   localparam int EXP_W       = 6;
   localparam int MANT_W      = 25;
   localparam int EXP_BIAS    = 31;
   localparam int FPU_LATENCY = 5;

   typedef enum logic [1:0] {
      EXACT     = 2'd0,
      INEXACT   = 2'd1,
      OVERFLOW  = 2'd2,
      UNDERFLOW = 2'd3
   } status_out_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } sched_state_t;

   // Upper status bits are always zero on a well-formed fpu status word.
   function automatic logic is_err_status(input logic [3:0] st);
      status_out_t code;
      code = status_out_t'(st[1:0]);
      return (st[3:2] == 2'b00) && ((code == OVERFLOW) || (code == UNDERFLOW));
   endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_rr_arbiter.sv
// fpu_rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap-around.
`default_nettype none

module fpu_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [PTR_W-1:0] idx
);

   always_comb begin
      logic           found;
      logic [PTR_W:0] pos;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         pos = {1'b0, ptr} + (PTR_W+1)'(k);
         if (pos >= (PTR_W+1)'(N_REQ)) begin
            pos = pos - (PTR_W+1)'(N_REQ);
         end
         if (!found && req[pos[PTR_W-1:0]]) begin
            found                  = 1'b1;
            grant[pos[PTR_W-1:0]] = 1'b1;
            idx                    = pos[PTR_W-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fpu_sched.sv
// fpu_sched: shares one free-running FPU_LATENCY-phase fpu among N_REQ requesters, one op per frame.
// Define FPU_SCHED_STATS_EN to add saturating completed-op and overflow/underflow counters.
`default_nettype none

module fpu_sched #(
   parameter int N_REQ       = 4,
   parameter int FPU_LATENCY = 5
) (
   input  logic                clock100KHz,
   input  logic                reset,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [N_REQ*32-1:0] req_op_a,
   input  logic [N_REQ*32-1:0] req_op_b,
   output logic [N_REQ-1:0]    req_ready,
   output logic [N_REQ-1:0]    rsp_valid,
   output logic [31:0]         rsp_data,
   output logic [3:0]          rsp_status,
   output logic [31:0]         fpu_op_a,
   output logic [31:0]         fpu_op_b,
   input  logic [31:0]         fpu_data,
   input  logic [3:0]          fpu_status,
   output logic                busy,
   output logic [15:0]         stat_ops,
   output logic [15:0]         stat_err
);

   import fpu_sched_pkg::*;

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int PH_W  = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(FPU_LATENCY - 1);

   logic [PH_W-1:0]  ph_q, ph_d;
   sched_state_t     state_q, state_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] owner_q, owner_d;
   logic [PTR_W-1:0] rsp_owner_q, rsp_owner_d;
   logic             cap_pend_q, cap_pend_d;
   logic [31:0]      op_a_q, op_a_d;
   logic [31:0]      op_b_q, op_b_d;
   logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_data_q, rsp_data_d;
   logic [3:0]       rsp_status_q, rsp_status_d;

   logic [N_REQ-1:0] arb_grant;
   logic [PTR_W-1:0] arb_idx;
   logic             arb_any;
   logic             slot;
   logic [31:0]      sel_a, sel_b;

   fpu_rr_arbiter #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (arb_grant),
      .idx   (arb_idx)
   );

   assign arb_any   = |arb_grant;
   assign slot      = (ph_q == PH_LAST);
   assign req_ready = slot ? arb_grant : '0;

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_grant[i]) begin
            sel_a = req_op_a[32*i +: 32];
            sel_b = req_op_b[32*i +: 32];
         end
      end
   end

   always_comb begin
      ph_d         = ph_q + 1'b1;
      state_d      = state_q;
      ptr_d        = ptr_q;
      owner_d      = owner_q;
      rsp_owner_d  = rsp_owner_q;
      cap_pend_d   = cap_pend_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      rsp_valid_d  = '0;
      rsp_data_d   = rsp_data_q;
      rsp_status_d = rsp_status_q;

      // Frame boundary: the in-flight result (if any) is complete; a new op may be issued.
      if (slot) begin
         ph_d        = '0;
         cap_pend_d  = (state_q == RUN);
         rsp_owner_d = owner_q;
         state_d     = arb_any ? RUN : IDLE;
         if (arb_any) begin
            owner_d = arb_idx;
            ptr_d   = (arb_idx == PTR_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
            op_a_d  = sel_a;
            op_b_d  = sel_b;
         end
      end

      if ((ph_q == '0) && cap_pend_q) begin
         rsp_data_d               = fpu_data;
         rsp_status_d             = fpu_status;
         rsp_valid_d[rsp_owner_q] = 1'b1;
         cap_pend_d               = 1'b0;
      end
   end

   always_ff @(posedge clock100KHz or negedge reset) begin
      if (!reset) begin
         ph_q         <= '0;
         state_q      <= IDLE;
         ptr_q        <= '0;
         owner_q      <= '0;
         rsp_owner_q  <= '0;
         cap_pend_q   <= 1'b0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         rsp_valid_q  <= '0;
         rsp_data_q   <= '0;
         rsp_status_q <= '0;
      end else begin
         ph_q         <= ph_d;
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         owner_q      <= owner_d;
         rsp_owner_q  <= rsp_owner_d;
         cap_pend_q   <= cap_pend_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_status_q <= rsp_status_d;
      end
   end

   assign fpu_op_a   = op_a_q;
   assign fpu_op_b   = op_b_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_status = rsp_status_q;
   assign busy       = (state_q == RUN);

`ifdef FPU_SCHED_STATS_EN
   logic [15:0] stat_ops_q, stat_ops_d;
   logic [15:0] stat_err_q, stat_err_d;

   always_comb begin
      stat_ops_d = stat_ops_q;
      stat_err_d = stat_err_q;
      if (|rsp_valid_q) begin
         if (stat_ops_q != 16'hFFFF) begin
            stat_ops_d = stat_ops_q + 16'd1;
         end
         if (is_err_status(rsp_status_q) && (stat_err_q != 16'hFFFF)) begin
            stat_err_d = stat_err_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clock100KHz or negedge reset) begin
      if (!reset) begin
         stat_ops_q <= '0;
         stat_err_q <= '0;
      end else begin
         stat_ops_q <= stat_ops_d;
         stat_err_q <= stat_err_d;
      end
   end

   assign stat_ops = stat_ops_q;
   assign stat_err = stat_err_q;
`else
   assign stat_ops = '0;
   assign stat_err = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpu_sched.sv
// tb_fpu_sched: fpu_sched with a behavioural stand-in fpu, checked every cycle against an event-list model.
`default_nettype none

module tb_fpu_sched;

   localparam int N   = 4;
   localparam int LAT = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*32-1:0] req_op_a = '0;
   logic [N*32-1:0] req_op_b = '0;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic [31:0]     rsp_data;
   logic [3:0]      rsp_status;
   logic [31:0]     fpu_op_a, fpu_op_b;
   logic [31:0]     fpu_data;
   logic [3:0]      fpu_status;
   logic            busy;
   logic [15:0]     stat_ops, stat_err;

   int checks = 0;
   int errs   = 0;

   always #5 clk = ~clk;

   fpu_sched #(.N_REQ(N), .FPU_LATENCY(LAT)) dut (
      .clock100KHz (clk),
      .reset       (rst_n),
      .req_valid   (req_valid),
      .req_op_a    (req_op_a),
      .req_op_b    (req_op_b),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_status  (rsp_status),
      .fpu_op_a    (fpu_op_a),
      .fpu_op_b    (fpu_op_b),
      .fpu_data    (fpu_data),
      .fpu_status  (fpu_status),
      .busy        (busy),
      .stat_ops    (stat_ops),
      .stat_err    (stat_err)
   );

   // Stand-in arithmetic: the scheduler only forwards this word, so any deterministic function works.
   function automatic logic [35:0] fpu_fn(input logic [31:0] a, input logic [31:0] b);
      logic [3:0] st;
      logic [5:0] ea, eb;
      ea = a[30:25];
      eb = b[30:25];
      if (ea == eb && ea >= 6'h3E)                                st = 4'd2;
      else if (ea == 6'd0 && eb == 6'd0 && (a[24:0] | b[24:0]) != 0) st = 4'd3;
      else if (a[0] ^ b[0])                                       st = 4'd1;
      else                                                        st = 4'd0;
      return {st, a + b};
   endfunction

   // Free-running fpu: operands taken at the end of phase 0, result presented from phase 0 of the next frame.
   int          fph;
   logic [31:0] fa, fb;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fph <= 0; fa <= '0; fb <= '0; fpu_data <= '0; fpu_status <= '0;
      end else begin
         if (fph == 0) begin
            fa <= fpu_op_a;
            fb <= fpu_op_b;
         end
         if (fph == LAT - 1) {fpu_status, fpu_data} <= fpu_fn(fa, fb);
         fph <= (fph == LAT - 1) ? 0 : fph + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: cycle index since reset, round-robin pointer, list of pending responses.
   typedef struct {
      int          due;
      int          owner;
      logic [31:0] data;
      logic [3:0]  st;
   } rsp_t;
   rsp_t        pend[$];
   int          cyc = 0;
   int          ptr_m = 0;
   int          busy_until = -1;
   int          ops_m = 0;
   int          err_m = 0;
   logic [31:0] op_a_m = '0, op_b_m = '0;
   int          w, pos;
   logic [N-1:0] exp_ready, exp_rsp;
   rsp_t        ev;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_ready", 32'(req_ready), 0);
         chk("rst_rsp_valid", 32'(rsp_valid), 0);
         chk("rst_rsp_data", rsp_data, 0);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_op_a", fpu_op_a, 0);
         chk("rst_stats", {stat_ops, stat_err}, 0);
         pend.delete();
         cyc = 0; ptr_m = 0; busy_until = -1; ops_m = 0; err_m = 0;
         op_a_m = '0; op_b_m = '0;
      end else begin
         w = -1;
         if (cyc % LAT == LAT - 1) begin
            for (int k = 0; k < N; k++) begin
               pos = (ptr_m + k) % N;
               if (w < 0 && req_valid[pos]) w = pos;
            end
         end
         exp_ready = (w >= 0) ? N'(1 << w) : '0;
         exp_rsp   = '0;
         if (pend.size() > 0 && pend[0].due == cyc) exp_rsp = N'(1 << pend[0].owner);

         chk("req_ready", 32'(req_ready), 32'(exp_ready));
         chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
         if (exp_rsp != 0) begin
            chk("rsp_data", rsp_data, pend[0].data);
            chk("rsp_status", 32'(rsp_status), 32'(pend[0].st));
         end
         chk("busy", 32'(busy), 32'(cyc <= busy_until));
         chk("fpu_op_a", fpu_op_a, op_a_m);
         chk("fpu_op_b", fpu_op_b, op_b_m);
`ifdef FPU_SCHED_STATS_EN
         chk("stat_ops", 32'(stat_ops), 32'(ops_m));
         chk("stat_err", 32'(stat_err), 32'(err_m));
`else
         chk("stat_tied", {stat_ops, stat_err}, 0);
`endif

         if (w >= 0) begin
            op_a_m = req_op_a[32*w +: 32];
            op_b_m = req_op_b[32*w +: 32];
            {ev.st, ev.data} = fpu_fn(op_a_m, op_b_m);
            ev.due   = cyc + LAT + 2;
            ev.owner = w;
            pend.push_back(ev);
            ptr_m      = (w + 1) % N;
            busy_until = cyc + LAT;
         end
         if (exp_rsp != 0) begin
            if (ops_m < 16'hFFFF) ops_m++;
            if ((pend[0].st == 4'd2 || pend[0].st == 4'd3) && err_m < 16'hFFFF) err_m++;
            void'(pend.pop_front());
         end
         cyc++;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic to_ph(input int p);
      for (int k = 0; k < LAT; k++) begin
         step(1);
         if (cyc % LAT == p) break;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b);
      req_valid[i]         = v;
      req_op_a[32*i +: 32] = a;
      req_op_b[32*i +: 32] = b;
   endtask

   task automatic gen_pair(output logic [31:0] a, output logic [31:0] b);
      case ($urandom_range(0, 3))
         0: begin a = {1'b0, 6'h3F, 25'($urandom)}; b = {1'b1, 6'h3F, 25'($urandom)}; end
         1: begin a = {1'b0, 6'h00, 25'($urandom)}; b = {1'b0, 6'h00, 25'($urandom)}; end
         default: begin a = $urandom; b = $urandom; end
      endcase
   endtask

   initial begin
      logic [31:0] a, b;
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a, b;

      // Reset values
      step(1);
      chk("reset_rsp_data", rsp_data, 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_op_a", fpu_op_a, 0);
      step(1);
      rst_n = 1'b1;

      // Single request, 7-cycle latency
      set_req(0, 1'b1, 32'h3F00_0000, 32'h3F00_0000);
      to_ph(4);
      chk("t1_grant", 32'(req_ready), 32'h1);
      step(1);
      req_valid[0] = 1'b0;
      step(6);
      chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t1_rsp_data", rsp_data, 32'h7E00_0000);
      chk("t1_rsp_status", 32'(rsp_status), 0);

      // Contention: grants 0,1,2,3 in consecutive frames, responses in the same order
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h1000_0000 * i + 32'd5, 32'h0000_0100 * i + 32'd2);
      for (int fr = 0; fr < N + 2; fr++) begin
         to_ph(1);
         if (fr >= 2) chk("t2_rsp_order", 32'(rsp_valid), 32'(1 << (fr - 2)));
         to_ph(4);
         if (fr < N) begin
            chk("t2_grant_order", 32'(req_ready), 32'(1 << fr));
            step(1);
            req_valid[fr] = 1'b0;
         end
      end

      // Withdrawn request never granted
      to_ph(0);
      set_req(2, 1'b1, 32'h1234_5678, 32'h0000_0001);
      to_ph(2);
      req_valid[2] = 1'b0;
      to_ph(4);
      chk("t3_no_grant", 32'(req_ready), 0);
      chk("t3_idle", 32'(busy), 0);
      step(12);

      // Asynchronous reset mid-flight
      do_reset();
      set_req(0, 1'b1, 32'h4400_0001, 32'h4400_0002);
      to_ph(4);
      step(1);
      req_valid[0] = 1'b0;
      to_ph(2);
      chk("t4_busy_before", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("t4_busy", 32'(busy), 0);
      chk("t4_op_a", fpu_op_a, 0);
      chk("t4_rsp_valid", 32'(rsp_valid), 0);
      step(3);
      rst_n = 1'b1;
      step(15);

      // Overflow status passthrough and counters
      do_reset();
      set_req(0, 1'b1, 32'h7E00_0000, 32'h7E00_0000);
      to_ph(4);
      step(1);
      req_valid[0] = 1'b0;
      step(6);
      chk("t5_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t5_status", 32'(rsp_status), 32'd2);
      step(1);
`ifdef FPU_SCHED_STATS_EN
      chk("t5_stat_err", 32'(stat_err), 1);
      chk("t5_stat_ops", 32'(stat_ops), 1);
`endif

      // Back-to-back from a single requester
      do_reset();
      gen_pair(a, b);
      set_req(1, 1'b1, a, b);
      for (int fr = 0; fr < 6; fr++) begin
         to_ph(1);
         if (fr >= 2) begin
            chk("t6_rsp_ph1", 32'(rsp_valid), 32'h2);
            chk("t6_busy", 32'(busy), 1);
         end
         to_ph(4);
         chk("t6_grant", 32'(req_ready), 32'h2);
         step(1);
         gen_pair(a, b);
         set_req(1, 1'b1, a, b);
      end
      req_valid = '0;
      step(10);

      // Randomized traffic, including one asynchronous reset
      for (int n = 0; n < 2000; n++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) req_valid[i] = ~req_valid[i];
            if ($urandom_range(0, 3) == 0) begin
               gen_pair(a, b);
               req_op_a[32*i +: 32] = a;
               req_op_b[32*i +: 32] = b;
            end
         end
         if (n == 1000) do_reset();
         step(1);
      end
      req_valid = '0;
      step(20);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

`default_nettype wire
